alu16_reg: RTL and testbench

- Registered 16-bit, two-operand ALU. Four operations: ADD, SUB, AND, OR, selected by a 2-bit opcode.
- Result and carry are captured on the rising clock edge, so latency is one cycle.
- Used as the arithmetic/logic execution stage of the datapath. Operands and opcode come from the register-read stage; the registered result feeds writeback.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_adder.sv | 24 ++
 rtl/alu16_reg.sv | 68 ++++++
 tb/tb_alu16_reg.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: default width, opcode encoding
// and the full-adder cell used by the ripple-carry adder.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  // One-bit full adder; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    logic s;
    logic co;
    s  = a ^ b ^ c;
    co = (a & b) | (c & (a ^ b));
    return {co, s};
  endfunction

endpackage

// File: rtl/alu_adder.sv
// WIDTH-bit ripple-carry adder chained from full-adder cells.
module alu_adder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign {carry[i+1], sum[i]} = full_add(a[i], b[i], carry[i]);
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/alu16_reg.sv
// Registered two-operand ALU (ADD/SUB/AND/OR) with one-cycle latency;
// ADD and SUB share a single adder with B inversion and carry-in injection.
module alu16_reg
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] o,
  output logic             cout
);

  logic             arith_c;
  logic [WIDTH-1:0] add_b_c;
  logic             add_cin_c;
  logic [WIDTH-1:0] add_sum_c;
  logic             add_cout_c;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;

  // SUB is i0 + ~i1 + 1; carry-in only when the op is arithmetic.
  assign arith_c   = ~op[1];
  assign add_b_c   = op[0] ? ~i1 : i1;
  assign add_cin_c = op[0] & arith_c;

  alu_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (i0),
    .b    (add_b_c),
    .cin  (add_cin_c),
    .sum  (add_sum_c),
    .cout (add_cout_c)
  );

  // Result select; logic ops never report a carry.
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    case (alu_op_e'(op))
      OP_ADD, OP_SUB: begin
        res_c   = add_sum_c;
        carry_c = add_cout_c;
      end
      OP_AND: res_c = i0 & i1;
      OP_OR:  res_c = i0 | i1;
      default: begin
        res_c   = '0;
        carry_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o    <= '0;
      cout <= 1'b0;
    end else begin
      o    <= res_c;
      cout <= carry_c;
    end
  end

endmodule

// File: tb/tb_alu16_reg.sv
// Scoreboard bench for alu16_reg: driver queues expected {cout,o} from an
// arithmetic reference model, monitor checks each registered result.
module tb_alu16_reg;

  localparam int unsigned W = 16;

  logic         clk;
  logic         reset;
  logic [1:0]   op;
  logic [W-1:0] i0;
  logic [W-1:0] i1;
  logic [W-1:0] o;
  logic         cout;

  logic [W:0]   exp_q[$];
  int           total;
  int           bad;
  int           idx;
  bit           drive_done;

  alu16_reg #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .i0    (i0),
    .i1    (i1),
    .o     (o),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: unsigned integer arithmetic, returns {cout, o}.
  function automatic logic [W:0] model(input logic [1:0] f, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned r;
    logic            c;
    ua = longint'(a);
    ub = longint'(b);
    r  = 0;
    c  = 1'b0;
    case (f)
      2'd0: begin r = (ua + ub) % 65536; c = (ua + ub) > 65535; end
      2'd1: begin r = (ua + 65536 - ub) % 65536; c = (ua >= ub); end
      2'd2: r = longint'(a & b);
      default: r = longint'(a | b);
    endcase
    return {c, W'(r)};
  endfunction

  task automatic apply(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic rst);
    @(negedge clk);
    reset = rst;
    op    = f;
    i0    = a;
    i1    = b;
    @(posedge clk);
    if (rst) exp_q.push_back('0);
    else     exp_q.push_back(model(f, a, b));
  endtask

  // Monitor: every registered result after a queued edge is checked.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W:0] e;
      e = exp_q.pop_front();
      total++;
      if ({cout, o} !== e) begin
        bad++;
        $display("FAIL result#%0d op=%b i0=%h i1=%h rst=%b: got o=%h cout=%b, want o=%h cout=%b",
                 idx, op, i0, i1, reset, o, cout, e[W-1:0], e[W]);
      end
      idx++;
    end
  end

  initial begin
    logic [W-1:0] pa[4];
    logic [W-1:0] pb[4];
    total = 0;
    bad   = 0;
    idx   = 0;
    drive_done = 1'b0;
    reset = 1'b1;
    op    = 2'b00;
    i0    = 16'hffff;
    i1    = 16'h0001;
    pa[0] = 16'h0000; pb[0] = 16'h0000;
    pa[1] = 16'haa55; pb[1] = 16'h55aa;
    pa[2] = 16'hffff; pb[2] = 16'h0001;
    pa[3] = 16'h0001; pb[3] = 16'h7fff;

    apply(2'b00, 16'hffff, 16'h0001, 1'b1);
    apply(2'b00, 16'hffff, 16'h0001, 1'b1);
    apply(2'b00, 16'hffff, 16'h0001, 1'b0);

    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 4; k++)
        apply(2'(f), pa[k], pb[k], 1'b0);

    // Reset for one edge mid-stream, then resume.
    apply(2'b01, 16'h1234, 16'h0034, 1'b0);
    apply(2'b00, 16'hffff, 16'h0001, 1'b1);
    apply(2'b00, 16'hffff, 16'h0001, 1'b0);

    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      apply(2'($urandom_range(0, 3)), a, b, ($urandom_range(0, 19) == 0));
    end

    drive_done = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: drive_done=%b, want 1", drive_done);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
